// File: rtl/cpu_pkg.sv
// Shared CPU constants: opcodes, branch condition codes, flag indices and fetch states.
package cpu_pkg;

    localparam logic [3:0] OPCODE_B   = 4'hC;
    localparam logic [3:0] OPCODE_BR  = 4'hD;
    localparam logic [3:0] OPCODE_HLT = 4'hF;

    localparam logic [2:0] COND_NEQ = 3'b000;
    localparam logic [2:0] COND_EQ  = 3'b001;
    localparam logic [2:0] COND_GT  = 3'b010;
    localparam logic [2:0] COND_LT  = 3'b011;
    localparam logic [2:0] COND_GE  = 3'b100;
    localparam logic [2:0] COND_LE  = 3'b101;
    localparam logic [2:0] COND_OVF = 3'b110;
    localparam logic [2:0] COND_UNC = 3'b111;

    localparam int unsigned FLAG_N = 2;
    localparam int unsigned FLAG_Z = 1;
    localparam int unsigned FLAG_V = 0;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } pc_state_t;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch condition evaluator over the {N,Z,V} flags.
module branch_cond_eval
    import cpu_pkg::*;
(
    input  logic [2:0] cond,
    input  logic [2:0] flags,
    output logic       cond_met
);

    logic n, z, v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign v = flags[FLAG_V];

    always_comb begin
        cond_met = 1'b0;
        unique case (cond)
            COND_NEQ: cond_met = ~z;
            COND_EQ:  cond_met = z;
            COND_GT:  cond_met = ~n & ~z;
            COND_LT:  cond_met = n;
            COND_GE:  cond_met = z | (~n & ~z);
            COND_LE:  cond_met = n | z;
            COND_OVF: cond_met = v;
            COND_UNC: cond_met = 1'b1;
            default:  cond_met = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch PC register for the pipelined core: sequential fetch, ID-stage redirects,
// and HLT detection with a fixed-length drain before reporting halted.
module pc_fetch_ctrl
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W                = 16,
    parameter logic [ADDR_W-1:0] RESET_PC        = '0,
    parameter int unsigned DRAIN_CYCLES          = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              fetch_valid,
    input  logic [15:0]       fetch_instr,
    input  logic              br_valid,
    input  logic              br_is_reg,
    input  logic [2:0]        br_cond,
    input  logic [8:0]        br_imm,
    input  logic [ADDR_W-1:0] br_pc,
    input  logic [ADDR_W-1:0] br_reg_val,
    input  logic [2:0]        flags,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus_two,
    output logic              flush,
    output logic              halted
);

    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

    logic [ADDR_W-1:0] pc_q, pc_d;
    pc_state_t         state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;

    logic              cond_met;
    logic              taken;
    logic              is_hlt;
    logic [ADDR_W-1:0] imm_ext;
    logic [ADDR_W-1:0] b_target;
    logic [ADDR_W-1:0] target;
    logic              unused_instr_bits;

    branch_cond_eval u_cond (
        .cond     (br_cond),
        .flags    (flags),
        .cond_met (cond_met)
    );

    // Only the opcode field matters at fetch.
    assign unused_instr_bits = ^fetch_instr[11:0];
    assign is_hlt            = (fetch_instr[15:12] == OPCODE_HLT);

    assign taken    = br_valid & ~stall & cond_met & (state_q != HALTED);
    assign imm_ext  = ADDR_W'($signed(br_imm));
    assign b_target = br_pc + ADDR_W'(2) + (imm_ext << 1);
    assign target   = br_is_reg ? br_reg_val : b_target;

    assign pc          = pc_q;
    assign pc_plus_two = pc_q + ADDR_W'(2);
    assign flush       = taken;
    assign halted      = (state_q == HALTED);

    always_comb begin
        pc_d    = pc_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        if (taken) begin
            // A redirect is older than anything in fetch, so it also cancels a pending drain.
            pc_d    = target;
            state_d = RUN;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (!stall && fetch_valid) begin
                        if (is_hlt) begin
                            state_d = DRAIN;
                            cnt_d   = DRAIN_LOAD;
                        end else begin
                            pc_d = pc_plus_two;
                        end
                    end
                end
                DRAIN: begin
                    if (cnt_q == 4'd0) begin
                        state_d = HALTED;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                HALTED: begin
                end
                default: begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            pc_q    <= pc_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: directed scenarios plus randomized traffic vs a model.
module tb_pc_fetch_ctrl;

    localparam int AW = 16;
    localparam int DC = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          stall;
    logic          fetch_valid;
    logic [15:0]   fetch_instr;
    logic          br_valid;
    logic          br_is_reg;
    logic [2:0]    br_cond;
    logic [8:0]    br_imm;
    logic [AW-1:0] br_pc;
    logic [AW-1:0] br_reg_val;
    logic [2:0]    flags;
    logic [AW-1:0] pc;
    logic [AW-1:0] pc_plus_two;
    logic          flush;
    logic          halted;

    pc_fetch_ctrl #(
        .ADDR_W       (AW),
        .RESET_PC     (16'h0000),
        .DRAIN_CYCLES (DC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .fetch_valid (fetch_valid),
        .fetch_instr (fetch_instr),
        .br_valid    (br_valid),
        .br_is_reg   (br_is_reg),
        .br_cond     (br_cond),
        .br_imm      (br_imm),
        .br_pc       (br_pc),
        .br_reg_val  (br_reg_val),
        .flags       (flags),
        .pc          (pc),
        .pc_plus_two (pc_plus_two),
        .flush       (flush),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Model: current pc, edges left until halt (0 = not draining), halted flag.
    logic [15:0] m_pc;
    int          m_left;
    bit          m_halted;

    function automatic bit m_cond(input logic [2:0] c, input logic [2:0] f);
        bit n, z, v;
        n = f[2];
        z = f[1];
        v = f[0];
        case (c)
            3'd0:    return !z;
            3'd1:    return z;
            3'd2:    return !n && !z;
            3'd3:    return n;
            3'd4:    return z || (!n && !z);
            3'd5:    return n || z;
            3'd6:    return v;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [15:0] m_target();
        int si;
        if (br_is_reg) return br_reg_val;
        si = br_imm[8] ? int'(br_imm) - 512 : int'(br_imm);
        return 16'((int'(br_pc) + 2 + 2 * si) & 32'hFFFF);
    endfunction

    function automatic bit m_taken();
        return !m_halted && br_valid && !stall && m_cond(br_cond, flags);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc     = 16'h0000;
        m_left   = 0;
        m_halted = 1'b0;
    endtask

    task automatic model_edge();
        if (!rst_n) begin
            model_reset();
        end else if (m_taken()) begin
            m_pc   = m_target();
            m_left = 0;
        end else if (m_halted) begin
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) m_halted = 1'b1;
        end else if (!stall && fetch_valid) begin
            if (fetch_instr[15:12] == 4'hF) m_left = DC;
            else m_pc = 16'(m_pc + 16'd2);
        end
    endtask

    // Compare outputs mid-cycle, then advance the model on the edge.
    task automatic tick();
        @(negedge clk);
        chk("pc", pc, m_pc);
        chk("pc_plus_two", pc_plus_two, 16'(m_pc + 16'd2));
        chk("flush", flush, m_taken());
        chk("halted", halted, m_halted);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_idle();
        stall       = 1'b0;
        fetch_valid = 1'b1;
        fetch_instr = 16'h1000;
        br_valid    = 1'b0;
        br_is_reg   = 1'b0;
        br_cond     = 3'd7;
        br_imm      = 9'd0;
        br_pc       = 16'h0000;
        br_reg_val  = 16'h0000;
        flags       = 3'b000;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hcnt;
        bit do_rst;
        rst_n = 1'b0;
        set_idle();
        model_reset();

        // Reset, then ten clean fetches.
        repeat (5) tick();
        rst_n = 1'b1;
        chk("rst_pc", pc, 16'h0000);
        chk("rst_halted", halted, 1'b0);
        repeat (10) tick();
        chk("run10_pc", pc, 16'h0014);

        // B taken with negative offset, then a not-taken B.
        br_valid = 1'b1; br_is_reg = 1'b0; br_pc = 16'h0040; br_imm = 9'h1FE; br_cond = 3'd7;
        #1 chk("b_flush", flush, 1'b1);
        tick();
        chk("b_pc", pc, 16'h003E);
        br_cond = 3'd1; flags = 3'b000;
        #1 chk("nt_flush", flush, 1'b0);
        tick();
        chk("nt_pc", pc, 16'h0040);

        // BR held off by stall, then taken.
        br_is_reg = 1'b1; br_reg_val = 16'h0123; br_cond = 3'd7; stall = 1'b1;
        #1 chk("br_stall_flush", flush, 1'b0);
        tick();
        chk("br_stall_pc", pc, 16'h0040);
        stall = 1'b0;
        #1 chk("br_flush", flush, 1'b1);
        tick();
        chk("br_pc", pc, 16'h0123);
        br_reg_val = 16'h0010;
        tick();
        br_valid = 1'b0;
        chk("to10_pc", pc, 16'h0010);

        // HLT drain: halted rises on the fourth edge after the HLT edge.
        fetch_instr = 16'hF000;
        tick();
        fetch_instr = 16'h1000;
        chk("hlt_pc", pc, 16'h0010);
        repeat (3) tick();
        chk("drain_halted", halted, 1'b0);
        chk("drain_pc", pc, 16'h0010);
        tick();
        chk("halt_rise", halted, 1'b1);
        br_valid = 1'b1; br_is_reg = 1'b1; br_cond = 3'd7; br_reg_val = 16'h0200;
        #1 chk("halt_flush", flush, 1'b0);
        tick();
        chk("halt_pc", pc, 16'h0010);
        chk("halt_stays", halted, 1'b1);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("halt_rst_halted", halted, 1'b0);
        set_idle();
        tick();
        rst_n = 1'b1;

        // HLT fetched alongside a taken B is discarded.
        br_valid = 1'b1; br_is_reg = 1'b0; br_pc = 16'h007E; br_imm = 9'd0; br_cond = 3'd7;
        fetch_instr = 16'hF000;
        tick();
        chk("cancel_pc", pc, 16'h0080);
        set_idle();
        tick();
        chk("cancel_run_pc", pc, 16'h0082);

        // Taken BR two cycles into DRAIN aborts the halt.
        fetch_instr = 16'hF000;
        tick();
        fetch_instr = 16'h1000;
        tick();
        br_valid = 1'b1; br_is_reg = 1'b1; br_reg_val = 16'h0456; br_cond = 3'd7;
        #1 chk("drain_br_flush", flush, 1'b1);
        tick();
        chk("drain_br_pc", pc, 16'h0456);
        set_idle();
        repeat (6) tick();
        chk("drain_br_run_pc", pc, 16'h0462);
        chk("drain_br_nohalt", halted, 1'b0);

        // Wrap-around.
        br_valid = 1'b1; br_is_reg = 1'b1; br_reg_val = 16'hFFFE; br_cond = 3'd7;
        tick();
        set_idle();
        chk("wrap_pre_pc", pc, 16'hFFFE);
        chk("wrap_pre_ppt", pc_plus_two, 16'h0000);
        tick();
        chk("wrap_pc", pc, 16'h0000);
        chk("wrap_ppt", pc_plus_two, 16'h0002);

        // Asynchronous reset in the middle of DRAIN.
        tick();
        fetch_instr = 16'hF000;
        tick();
        fetch_instr = 16'h1000;
        tick();
        chk("pre_rst_pc", pc, 16'h0002);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("mid_rst_pc", pc, 16'h0000);
        chk("mid_rst_halted", halted, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_pc", pc, 16'h0002);

        // Randomized traffic against the model.
        hcnt = 0;
        for (int i = 0; i < 3000; i++) begin
            do_rst = (m_halted && hcnt > 2) || ($urandom_range(0, 199) == 0);
            hcnt   = m_halted ? hcnt + 1 : 0;
            if (do_rst) begin
                rst_n = 1'b0;
                #1;
                model_reset();
                hcnt = 0;
            end else begin
                rst_n = 1'b1;
            end
            stall       = ($urandom_range(0, 4) == 0);
            fetch_valid = ($urandom_range(0, 4) != 0);
            if ($urandom_range(0, 29) == 0) fetch_instr = {4'hF, 12'($urandom)};
            else fetch_instr = {4'($urandom_range(0, 14)), 12'($urandom)};
            br_valid    = ($urandom_range(0, 5) == 0);
            br_is_reg   = 1'($urandom);
            br_cond     = 3'($urandom);
            br_imm      = 9'($urandom);
            br_pc       = 16'($urandom);
            br_reg_val  = 16'($urandom);
            flags       = 3'($urandom);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
